// File: rtl/weighted_rr_queue_arbiter.sv
// Weighted round-robin arbiter with per-channel pending-request counters.
// Each channel queues up to DEPTH requests. The owner keeps the grant for up
// to its weight of back-to-back transfers, then ownership rotates. grant,
// grant_valid and drop are driven straight from registers.
module weighted_rr_queue_arbiter #(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int WW    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*WW-1:0] weight,
   input  logic            grant_ready,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [N-1:0]    drop
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [OW-1:0] owner_q, owner_d;
   logic [WW-1:0] burst_q, burst_d;
   logic [N-1:0]  grant_q, grant_d;
   logic          grant_valid_q, grant_valid_d;
   logic [N-1:0]  drop_q, drop_d;

   logic          hs;
   logic [N-1:0]  hs_vec;
   logic          found;
   logic [OW-1:0] pick;
   logic [OW-1:0] scan_idx;
   logic [WW-1:0] w_own;
   logic [WW-1:0] ew;
   logic [WW:0]   burst_inc;

   // Per-channel queue counters: enqueue on req, dequeue on handshake, drop when full.
   always_comb begin
      hs     = grant_valid_q & grant_ready;
      hs_vec = '0;
      drop_d = '0;
      for (int unsigned i = 0; i < N; i++) begin
         hs_vec[i] = hs && (owner_q == OW'(i));
         cnt_d[i]  = cnt_q[i];
         if (req[i] && !hs_vec[i]) begin
            if (cnt_q[i] == CW'(DEPTH)) begin
               drop_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else if (hs_vec[i] && !req[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   // Next-owner scan on updated counts: owner+1 .. owner+N-1, then owner itself last.
   always_comb begin
      found    = 1'b0;
      pick     = owner_q;
      scan_idx = owner_q;
      for (int unsigned k = 1; k <= N; k++) begin
         scan_idx = OW'((32'(owner_q) + k) % N);
         if (!found && (cnt_d[scan_idx] != '0)) begin
            found = 1'b1;
            pick  = scan_idx;
         end
      end
   end

   // Live effective weight of the current owner (0 counts as 1).
   always_comb begin
      w_own     = weight[32'(owner_q)*WW +: WW];
      ew        = (w_own == '0) ? WW'(1) : w_own;
      burst_inc = {1'b0, burst_q} + 1'b1;
   end

   // Ownership and burst update: rotate on burst end or drained owner, reselect when idle,
   // hold everything under backpressure.
   always_comb begin
      owner_d = owner_q;
      burst_d = burst_q;
      if (hs) begin
         if ((burst_inc >= {1'b0, ew}) || (cnt_d[owner_q] == '0)) begin
            burst_d = '0;
            if (found) begin
               owner_d = pick;
            end
         end else begin
            burst_d = burst_q + 1'b1;
         end
      end else if (!grant_valid_q && found) begin
         owner_d = pick;
         burst_d = '0;
      end
      // Outputs are registered, so they are precomputed from next-state values.
      grant_valid_d = (cnt_d[owner_d] != '0);
      grant_d       = grant_valid_d ? (N'(1) << owner_d) : '0;
   end

   // State and registered outputs; synchronous reset clears all pending work.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '{default: '0};
         owner_q       <= '0;
         burst_q       <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         drop_q        <= '0;
      end else begin
         cnt_q         <= cnt_d;
         owner_q       <= owner_d;
         burst_q       <= burst_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         drop_q        <= drop_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign drop        = drop_q;

endmodule
